// File: rtl/prefetch_unpack_pkg.sv
// Shared constants and helpers for the prefetch FIFO pixel unpacker.
// Default word/pixel widths, the default fill pixel, and the slice-pointer sizing helpers.
package prefetch_unpack_pkg;

    localparam int             DATA_W_DEF   = 32;
    localparam int             PIX_W_DEF    = 16;
    localparam logic [15:0]    FILL_PIX_DEF = 16'h0000;
    localparam int             UF_CNT_W     = 16;

    function automatic int clog2(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return res;
    endfunction

    function automatic int ratio_of(input int data_w, input int pix_w);
        return data_w / pix_w;
    endfunction

    // A single-slice word still gets a 1-bit pointer so the port never collapses to zero width.
    function automatic int sel_w_of(input int ratio);
        return (ratio > 1) ? clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/prefetch_unpack_slice_mux.sv
// Picks pixel slice 'sel' out of the held FIFO word; slice 0 is the LSB end.
module prefetch_unpack_slice_mux
    import prefetch_unpack_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int PIX_W  = PIX_W_DEF,
    parameter int SEL_W  = sel_w_of(ratio_of(DATA_W_DEF, PIX_W_DEF))
) (
    input  logic [DATA_W-1:0] word_i,
    input  logic [SEL_W-1:0]  sel_i,
    output logic [PIX_W-1:0]  pix_o
);

    assign pix_o = word_i[int'(sel_i) * PIX_W +: PIX_W];

endmodule

// File: rtl/prefetch_fifo_pixel_unpacker.sv
// Read-side consumer of the show-ahead prefetch FIFO: pops words, serves one pixel per pix_req
// one cycle later, and substitutes FILL_PIX with an underflow pulse when no word is held.
// Optional saturating underflow counter enabled by `define PREFETCH_UNPACK_UFCNT_EN.
module prefetch_fifo_pixel_unpacker
    import prefetch_unpack_pkg::*;
#(
    parameter int               DATA_W   = DATA_W_DEF,
    parameter int               PIX_W    = PIX_W_DEF,
    parameter logic [PIX_W-1:0] FILL_PIX = PIX_W'(FILL_PIX_DEF)
) (
    input  logic                rd_clk,
    input  logic                rd_rst,
    input  logic [DATA_W-1:0]   fifo_rd_data,
    input  logic                fifo_rd_vld,
    output logic                fifo_rd_en,
    input  logic                frame_start,
    input  logic                pix_req,
    output logic [PIX_W-1:0]    pix_data,
    output logic                pix_vld,
    output logic                underflow,
    output logic [UF_CNT_W-1:0] uf_cnt
);

    localparam int RATIO = ratio_of(DATA_W, PIX_W);
    localparam int SEL_W = sel_w_of(RATIO);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(RATIO - 1);

    logic [DATA_W-1:0] word_q, word_d;
    logic              word_vld_q, word_vld_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [PIX_W-1:0]  pix_data_q, pix_data_d;
    logic              pix_vld_q, pix_vld_d;
    logic              uf_q, uf_d;

    logic [PIX_W-1:0]  slice;
    logic              flush, held, last, consume, pop;

    prefetch_unpack_slice_mux #(
        .DATA_W (DATA_W),
        .PIX_W  (PIX_W),
        .SEL_W  (SEL_W)
    ) u_slice_mux (
        .word_i (word_q),
        .sel_i  (sel_q),
        .pix_o  (slice)
    );

    // Fetch control and next-state: a started word is dropped on frame_start before the request
    // is served, and a word popped this cycle only becomes usable from the next request.
    always_comb begin
        flush   = frame_start & (sel_q != '0);
        held    = word_vld_q & ~flush;
        last    = (sel_q == SEL_LAST);
        consume = pix_req & held & last;
        pop     = ~rd_rst & fifo_rd_vld & (~word_vld_q | consume | flush);

        word_d     = word_q;
        word_vld_d = word_vld_q;
        sel_d      = sel_q;
        pix_data_d = pix_data_q;
        pix_vld_d  = 1'b0;
        uf_d       = 1'b0;

        if (flush) begin
            word_vld_d = 1'b0;
            sel_d      = '0;
        end

        if (pix_req) begin
            pix_vld_d = 1'b1;
            if (held) begin
                pix_data_d = slice;
                if (last) begin
                    sel_d      = '0;
                    word_vld_d = 1'b0;
                end else begin
                    sel_d = sel_q + 1'b1;
                end
            end else begin
                pix_data_d = FILL_PIX;
                uf_d       = 1'b1;
            end
        end

        if (pop) begin
            word_d     = fifo_rd_data;
            word_vld_d = 1'b1;
            sel_d      = '0;
        end
    end

    // Word register, slice pointer and registered pixel outputs.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            word_q     <= '0;
            word_vld_q <= 1'b0;
            sel_q      <= '0;
            pix_data_q <= '0;
            pix_vld_q  <= 1'b0;
            uf_q       <= 1'b0;
        end else begin
            word_q     <= word_d;
            word_vld_q <= word_vld_d;
            sel_q      <= sel_d;
            pix_data_q <= pix_data_d;
            pix_vld_q  <= pix_vld_d;
            uf_q       <= uf_d;
        end
    end

    assign fifo_rd_en = pop;
    assign pix_data   = pix_data_q;
    assign pix_vld    = pix_vld_q;
    assign underflow  = uf_q;

`ifdef PREFETCH_UNPACK_UFCNT_EN
    logic [UF_CNT_W-1:0] uf_cnt_q, uf_cnt_d;

    // Per-frame underflow count; an underflow in the frame_start cycle belongs to the new frame.
    always_comb begin
        uf_cnt_d = uf_cnt_q;
        if (frame_start) begin
            uf_cnt_d = {{(UF_CNT_W-1){1'b0}}, uf_d};
        end else if (uf_d && (uf_cnt_q != {UF_CNT_W{1'b1}})) begin
            uf_cnt_d = uf_cnt_q + 1'b1;
        end
    end

    // Underflow counter register.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            uf_cnt_q <= '0;
        end else begin
            uf_cnt_q <= uf_cnt_d;
        end
    end

    assign uf_cnt = uf_cnt_q;
`else
    assign uf_cnt = '0;
`endif

endmodule
